cpu_fetch_buffer: RTL and testbench

CPU_FETCH_BUFFER -- requirements
Module: cpu_fetch_buffer

---
 rtl/cpu_fetch_buffer.sv | 72 +++++++
 tb/tb_cpu_fetch_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_buffer.sv
// cpu_fetch_buffer: toggle-handshake FIFO between the fetch and decode stages.
// Entry layout (msb..lsb): strobe, instruction[31:0], pc[31:0], inst_rs1[4:0],
// inst_rs2[4:0], inst_rs3[4:0], inst_rd[4:0]; everything below strobe is opaque payload.
module cpu_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_flush,
    input  logic [84:0]              i_data,
    output logic                     o_busy,
    output logic [84:0]              o_data,
    input  logic                     i_busy,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int W  = 85;

    logic [W-2:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          last_strobe;
    logic          in_event;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // Decode this cycle's push, pop and overflow-drop from the toggle event and level.
    always_comb begin
        in_event = i_data[W-1] != last_strobe;
        full     = o_level == LW'(DEPTH);
        push     = in_event && !i_flush && !full;
        drop     = in_event && !i_flush && full;
        pop      = o_level != '0 && !i_busy && !i_flush;
    end

    // Busy one entry early so the entry fetch may already have in flight still fits.
    assign o_busy = o_level >= LW'(DEPTH - 1);

    // Payload storage; never reset since the level gates every read.
    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr] <= i_data[W-2:0];
    end

    // Pointers, level, strobe tracking, head register and sticky overflow.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_level     <= '0;
            last_strobe <= 1'b0;
            o_data      <= '0;
            o_overflow  <= 1'b0;
        end else begin
            last_strobe <= i_data[W-1];
            if (drop) o_overflow <= 1'b1;
            if (i_flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                o_level <= '0;
            end else begin
                wr_ptr  <= wr_ptr + AW'(push);
                rd_ptr  <= rd_ptr + AW'(pop);
                o_level <= o_level + LW'(push) - LW'(pop);
            end
            if (pop) o_data <= {~o_data[W-1], mem[rd_ptr]};
        end
    end
endmodule

// File: tb/tb_cpu_fetch_buffer.sv
// tb_cpu_fetch_buffer: directed checks of the toggle-handshake fetch buffer (DEPTH=4).
module tb_cpu_fetch_buffer;
    logic        i_clock;
    logic        i_reset_n;
    logic        i_flush;
    logic [84:0] i_data;
    logic        o_busy;
    logic [84:0] o_data;
    logic        i_busy;
    logic [2:0]  o_level;
    logic        o_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic in_s = 1'b0;
    logic os = 1'b0;

    cpu_fetch_buffer #(.DEPTH(4)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_data(i_data),
        .o_busy(o_busy), .o_data(o_data), .i_busy(i_busy), .o_level(o_level),
        .o_overflow(o_overflow)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    function automatic logic [84:0] mk(input logic s, input logic [31:0] pc);
        return {s, ~pc, pc, pc[6:2], pc[11:7], pc[4:0] ^ 5'h1f, pc[9:5]};
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input logic [31:0] pc);
        in_s   = ~in_s;
        i_data = mk(in_s, pc);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] pc);
        os = ~os;
        chk(tag, 96'(o_data), 96'(mk(os, pc)));
    endtask

    initial begin
        logic [15:0] pat;
        int sent;
        int recv;
        logic prev;
        pat = 16'b0110_1001_1100_0101;
        i_reset_n = 1'b0;
        i_flush = 1'b0;
        i_busy = 1'b0;
        i_data = '0;
        #12;
        chk("rst_level", 96'(o_level), 96'd0);
        chk("rst_busy", 96'(o_busy), 96'd0);
        chk("rst_ovf", 96'(o_overflow), 96'd0);
        chk("rst_data", 96'(o_data), 96'd0);
        #1 i_reset_n = 1'b1;
        tick();
        // single entry, two-edge latency
        send(32'h100);
        tick();
        chk("single_lvl1", 96'(o_level), 96'd1);
        chk("single_nostrobe", 96'(o_data[84]), 96'd0);
        tick();
        pop_chk("single_data", 32'h100);
        chk("single_lvl0", 96'(o_level), 96'd0);
        // fill under back-pressure
        i_busy = 1'b1;
        send(32'h200); tick();
        send(32'h204); tick();
        chk("fill_busy_lo", 96'(o_busy), 96'd0);
        send(32'h208); tick();
        chk("fill_lvl3", 96'(o_level), 96'd3);
        chk("fill_busy_hi", 96'(o_busy), 96'd1);
        send(32'h20c); tick();
        chk("fill_lvl4", 96'(o_level), 96'd4);
        chk("fill_no_ovf", 96'(o_overflow), 96'd0);
        chk("fill_head_hold", 96'(o_data), 96'(mk(os, 32'h100)));
        i_busy = 1'b0;
        tick(); pop_chk("drain0", 32'h200); chk("drain_lvl3", 96'(o_level), 96'd3);
        tick(); pop_chk("drain1", 32'h204);
        tick(); pop_chk("drain2", 32'h208);
        tick(); pop_chk("drain3", 32'h20c); chk("drain_lvl0", 96'(o_level), 96'd0);
        // asynchronous reset mid-cycle with level 3
        i_busy = 1'b1;
        send(32'h400); tick();
        send(32'h404); tick();
        send(32'h408); tick();
        chk("arst_pre_lvl", 96'(o_level), 96'd3);
        #2 i_reset_n = 1'b0;
        i_data = '0;
        in_s = 1'b0;
        #1;
        chk("arst_lvl", 96'(o_level), 96'd0);
        chk("arst_data", 96'(o_data), 96'd0);
        chk("arst_busy", 96'(o_busy), 96'd0);
        os = 1'b0;
        #2 i_reset_n = 1'b1;
        i_busy = 1'b0;
        tick();
        chk("arst_post_lvl", 96'(o_level), 96'd0);
        chk("arst_post_strobe", 96'(o_data[84]), 96'd0);
        // flush colliding with an input toggle
        i_busy = 1'b1;
        send(32'h300); tick();
        send(32'h304); tick();
        chk("flush_pre_lvl", 96'(o_level), 96'd2);
        i_busy = 1'b0;
        i_flush = 1'b1;
        send(32'h308);
        tick();
        i_flush = 1'b0;
        chk("flush_lvl", 96'(o_level), 96'd0);
        chk("flush_data", 96'(o_data), 96'd0);
        chk("flush_ovf", 96'(o_overflow), 96'd0);
        tick();
        chk("flush_no_pop", 96'(o_data), 96'd0);
        send(32'h30c); tick(); tick();
        pop_chk("flush_next", 32'h30c);
        // wrap-around stream with pseudo-random decode back-pressure
        sent = 0;
        recv = 0;
        prev = o_data[84];
        for (int c = 0; c < 100 && recv < 10; c++) begin
            if (o_data[84] != prev) begin
                prev = o_data[84];
                pop_chk($sformatf("wrap%0d", recv), 32'(recv * 4));
                recv++;
            end
            i_busy = pat[c % 16];
            if (sent < 10 && !o_busy) begin
                send(32'(sent * 4));
                sent++;
            end
            tick();
        end
        i_busy = 1'b0;
        tick(); tick();
        chk("wrap_count", 96'(recv), 96'd10);
        chk("wrap_no_extra", 96'(o_data[84]), 96'(os));
        // overflow: fifth entry while full is dropped
        i_busy = 1'b1;
        send(32'h500); tick();
        send(32'h504); tick();
        send(32'h508); tick();
        send(32'h50c); tick();
        send(32'h510); tick();
        chk("ovf_flag", 96'(o_overflow), 96'd1);
        chk("ovf_lvl", 96'(o_level), 96'd4);
        i_busy = 1'b0;
        tick(); pop_chk("ovf_drain0", 32'h500);
        tick(); pop_chk("ovf_drain1", 32'h504);
        tick(); pop_chk("ovf_drain2", 32'h508);
        tick(); pop_chk("ovf_drain3", 32'h50c);
        tick(); tick();
        chk("ovf_no_drop_out", 96'(o_data), 96'(mk(os, 32'h50c)));
        chk("ovf_sticky", 96'(o_overflow), 96'd1);
        chk("ovf_lvl0", 96'(o_level), 96'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
